// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: nibble-serial control sequencer for the SM83 8-bit ALU group (ADD..CP).
// Define SM83_ALU_SEQ_B2B_EN to let a new op issue directly from HI.
module sm83_alu_seq #(
  parameter int ALU_WIDTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [2:0] i_op,
  input  logic       i_flag_c_in,
  input  logic       i_alu_carry,
  input  logic       i_alu_zero,
  output logic       o_din_sel,
  output logic       o_shift_oe,
  output logic       o_load_a,
  output logic       o_load_b,
  output logic       o_result_oe,
  output logic       o_no_carry_out,
  output logic       o_force_carry,
  output logic       o_ignore_carry,
  output logic       o_negate,
  output logic       o_carry_in,
  output logic       o_mux,
  output logic       o_op_b_mux,
  output logic       o_busy,
  output logic       o_wb,
  output logic       o_done,
  output logic       o_flag_z,
  output logic       o_flag_n,
  output logic       o_flag_h,
  output logic       o_flag_c
);
  // state | meaning
  // IDLE  | waiting for start
  // LDA   | operand A (accumulator) loaded from the bus
  // LDB   | operand B loaded from the bus
  // LO    | low nibble pass, core carry captured into lo_c
  // HI    | high nibble pass, write-back and flag update
  typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_LO, S_HI} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  if (ALU_WIDTH != 4) begin : g_width_check
    $error("sm83_alu_seq flag rules are defined for ALU_WIDTH == 4 only");
  end

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;
  logic       r_cin;
  logic       r_lo_c;
  logic       r_done;
  logic       r_flag_z, r_flag_n, r_flag_h, r_flag_c;
  logic       w_accept;
  logic       w_logic;
  logic       w_sub;
  logic       w_flag_z, w_flag_n, w_flag_h, w_flag_c;

  assign w_logic = r_op[2] & (r_op != OP_CP);
  assign w_sub   = ~w_logic & (r_op[1] | r_op[2]);

  // Subtraction runs as A + ~B + cin, so the core carry is an inverted borrow.
  assign w_flag_z = i_alu_zero;
  assign w_flag_n = w_sub;
  assign w_flag_h = w_logic ? (r_op == OP_AND) : (r_lo_c ^ w_sub);
  assign w_flag_c = w_logic ? 1'b0 : (i_alu_carry ^ w_sub);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next   = S_LDA;
          w_accept = 1'b1;
        end
      end
      S_LDA: w_next = S_LDB;
      S_LDB: w_next = S_LO;
      S_LO:  w_next = S_HI;
      S_HI: begin
`ifdef SM83_ALU_SEQ_B2B_EN
        if (i_start) begin
          w_next   = S_LDA;
          w_accept = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_din_sel      = 1'b0;
    o_shift_oe     = 1'b0;
    o_load_a       = 1'b0;
    o_load_b       = 1'b0;
    o_result_oe    = 1'b0;
    o_no_carry_out = 1'b0;
    o_force_carry  = 1'b0;
    o_ignore_carry = 1'b0;
    o_negate       = 1'b0;
    o_carry_in     = 1'b0;
    o_mux          = 1'b0;
    o_op_b_mux     = 1'b0;
    o_busy         = 1'b0;
    o_wb           = 1'b0;
    case (r_state)
      S_LDA: begin
        o_busy     = 1'b1;
        o_shift_oe = 1'b1;
        o_load_a   = 1'b1;
      end
      S_LDB: begin
        o_busy     = 1'b1;
        o_shift_oe = 1'b1;
        o_load_b   = 1'b1;
        o_din_sel  = 1'b1;
      end
      S_LO, S_HI: begin
        o_busy         = 1'b1;
        o_no_carry_out = (r_op == OP_XOR) | (r_op == OP_OR);
        o_ignore_carry = (r_op == OP_OR);
        o_force_carry  = (r_op == OP_AND);
        o_negate       = w_sub;
        if (r_state == S_LO) begin
          case (r_op)
            OP_ADD:        o_carry_in = 1'b0;
            OP_ADC:        o_carry_in = r_cin;
            OP_SUB, OP_CP: o_carry_in = 1'b1;
            OP_SBC:        o_carry_in = ~r_cin;
            OP_AND:        o_carry_in = 1'b1;
            default:       o_carry_in = 1'b0;
          endcase
        end else begin
          o_mux       = 1'b1;
          o_op_b_mux  = 1'b1;
          o_result_oe = 1'b1;
          o_wb        = (r_op != OP_CP);
          o_carry_in  = w_logic ? (r_op == OP_AND) : r_lo_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_cin    <= 1'b0;
      r_lo_c   <= 1'b0;
      r_done   <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_h <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_HI);
      if (w_accept) begin
        r_op  <= i_op;
        // A chained op must see the carry being produced right now, not the stale port value.
        r_cin <= (r_state == S_HI) ? w_flag_c : i_flag_c_in;
      end
      if (r_state == S_LO) r_lo_c <= i_alu_carry;
      if (r_state == S_HI) begin
        r_flag_z <= w_flag_z;
        r_flag_n <= w_flag_n;
        r_flag_h <= w_flag_h;
        r_flag_c <= w_flag_c;
      end
    end
  end

  assign o_done   = r_done;
  assign o_flag_z = r_flag_z;
  assign o_flag_n = r_flag_n;
  assign o_flag_h = r_flag_h;
  assign o_flag_c = r_flag_c;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Bench for sm83_alu_seq: a nibble ALU datapath model answers the strobes, and
// byte-level SM83 arithmetic provides the expected results and flags.
`timescale 1ns/1ps
module tb_sm83_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, flag_c_in, alu_carry, alu_zero;
  logic [2:0] op;
  logic       din_sel, shift_oe, load_a, load_b, result_oe;
  logic       no_carry_out, force_carry, ignore_carry, negate, carry_in;
  logic       mux, op_b_mux, busy, wb, done;
  logic       flag_z, flag_n, flag_h, flag_c;

  int n_checks = 0;
  int n_fail   = 0;

  sm83_alu_seq #(.ALU_WIDTH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_flag_c_in(flag_c_in),
    .i_alu_carry(alu_carry), .i_alu_zero(alu_zero),
    .o_din_sel(din_sel), .o_shift_oe(shift_oe), .o_load_a(load_a), .o_load_b(load_b),
    .o_result_oe(result_oe), .o_no_carry_out(no_carry_out), .o_force_carry(force_carry),
    .o_ignore_carry(ignore_carry), .o_negate(negate), .o_carry_in(carry_in),
    .o_mux(mux), .o_op_b_mux(op_b_mux), .o_busy(busy), .o_wb(wb), .o_done(done),
    .o_flag_z(flag_z), .o_flag_n(flag_n), .o_flag_h(flag_h), .o_flag_c(flag_c)
  );

  // Datapath model: operand registers and low result nibble load on the falling edge.
  logic [7:0] tb_a, tb_b, m_a, m_b;
  logic [3:0] m_lo_res, m_na, m_nb, m_res;
  logic [4:0] m_sum;

  always_comb begin
    m_na  = mux ? m_a[7:4] : m_a[3:0];
    m_nb  = op_b_mux ? m_b[7:4] : m_b[3:0];
    if (negate) m_nb = ~m_nb;
    m_sum = {1'b0, m_na} + {1'b0, m_nb} + {4'b0, carry_in};
    if (force_carry)       m_res = m_na & m_nb;
    else if (no_carry_out) m_res = ignore_carry ? (m_na | m_nb) : (m_na ^ m_nb);
    else                   m_res = m_sum[3:0];
    alu_carry = (no_carry_out | force_carry) ? 1'b0 : m_sum[4];
    alu_zero  = (m_res == 4'h0) && (!mux || m_lo_res == 4'h0);
  end

  always @(negedge clk) begin
    if (load_a) m_a <= din_sel ? tb_b : tb_a;
    if (load_b) m_b <= din_sel ? tb_b : tb_a;
    if (busy && !shift_oe && !mux) m_lo_res <= m_res;
  end

  // Returns {result[7:0], Z, N, H, C}.
  function automatic logic [11:0] ref_alu(input logic [2:0] f_op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
    int ia, ib, ci, r;
    logic z, n, h, cy;
    ia = int'(a); ib = int'(b); ci = c ? 1 : 0;
    r = 0; n = 1'b0; h = 1'b0; cy = 1'b0;
    case (f_op)
      3'd0, 3'd1: begin
        if (f_op == 3'd0) ci = 0;
        r  = ia + ib + ci;
        h  = (ia % 16 + ib % 16 + ci) > 15;
        cy = r > 255;
      end
      3'd2, 3'd3, 3'd7: begin
        if (f_op != 3'd3) ci = 0;
        r  = ia - ib - ci;
        h  = (ia % 16) < (ib % 16 + ci);
        cy = r < 0;
        n  = 1'b1;
      end
      3'd4: begin r = ia & ib; h = 1'b1; end
      3'd5: r = ia ^ ib;
      default: r = ia | ib;
    endcase
    z = (r & 255) == 0;
    return {8'(r & 255), z, n, h, cy};
  endfunction

  task automatic run_op(input logic [2:0] t_op, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    logic [11:0] exp;
    logic [2:0]  exp_ctl;
    logic [3:0]  exp_ld;
    logic        exp_cin, exp_neg;
    exp     = ref_alu(t_op, a, b, c);
    exp_neg = (t_op == 3'd2) || (t_op == 3'd3) || (t_op == 3'd7);
    case (t_op)
      3'd0:       exp_cin = 1'b0;
      3'd1:       exp_cin = c;
      3'd2, 3'd7: exp_cin = 1'b1;
      3'd3:       exp_cin = ~c;
      3'd4:       exp_cin = 1'b1;
      default:    exp_cin = 1'b0;
    endcase
    tb_a = a; tb_b = b; op = t_op; flag_c_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); flag_c_in = 1'($urandom);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      exp_ctl = {cyc <= 4, (cyc == 4) && (t_op != 3'd7), cyc == 5};
      exp_ld  = (cyc == 1) ? 4'b1100 : (cyc == 2) ? 4'b1011 : 4'b0000;
      n_checks++;
      if ({busy, wb, done} !== exp_ctl) begin
        n_fail++;
        $display("FAIL seq op=%0d cyc=%0d busy/wb/done got=%b exp=%b", t_op, cyc, {busy, wb, done}, exp_ctl);
      end
      n_checks++;
      if ({shift_oe, load_a, load_b, din_sel} !== exp_ld) begin
        n_fail++;
        $display("FAIL load op=%0d cyc=%0d shift/lda/ldb/sel got=%b exp=%b", t_op, cyc,
                 {shift_oe, load_a, load_b, din_sel}, exp_ld);
      end
      if (cyc == 3) begin
        n_checks++;
        if ({negate, carry_in, mux} !== {exp_neg, exp_cin, 1'b0}) begin
          n_fail++;
          $display("FAIL lo_ctl op=%0d neg/cin/mux got=%b exp=%b", t_op, {negate, carry_in, mux},
                   {exp_neg, exp_cin, 1'b0});
        end
      end
      if (cyc == 4 && t_op != 3'd7) begin
        n_checks++;
        if ({m_res, m_lo_res} !== exp[11:4] || result_oe !== 1'b1) begin
          n_fail++;
          $display("FAIL result op=%0d a=%h b=%h c=%b got=%h oe=%b exp=%h", t_op, a, b, c,
                   {m_res, m_lo_res}, result_oe, exp[11:4]);
        end
      end
      if (cyc == 5) begin
        n_checks++;
        if ({flag_z, flag_n, flag_h, flag_c} !== exp[3:0]) begin
          n_fail++;
          $display("FAIL flags op=%0d a=%h b=%h c=%b got=%b exp=%b", t_op, a, b, c,
                   {flag_z, flag_n, flag_h, flag_c}, exp[3:0]);
        end
      end
      if (cyc < 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; flag_c_in = 1'b0; tb_a = 8'h00; tb_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({din_sel, shift_oe, load_a, load_b, result_oe, no_carry_out, force_carry, ignore_carry,
         negate, carry_in, mux, op_b_mux, busy, wb, done, flag_z, flag_n, flag_h, flag_c} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b wb=%b done=%b flags=%b exp all zero", busy, wb, done,
               {flag_z, flag_n, flag_h, flag_c});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(3'd0, 8'h3A, 8'hC6, 1'b0);
    run_op(3'd2, 8'h3E, 8'h3E, 1'b0);
    run_op(3'd3, 8'h3B, 8'h2A, 1'b1);
    run_op(3'd7, 8'h3C, 8'h40, 1'b0);
    run_op(3'd4, 8'h5A, 8'h3F, 1'b0);
    run_op(3'd6, 8'h00, 8'h00, 1'b0);
    run_op(3'd5, 8'hA5, 8'hA5, 1'b1);
    run_op(3'd1, 8'h0F, 8'hF0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_abort();
    run_op(3'd0, 8'h3A, 8'hC6, 1'b0);
    tb_a = 8'h3A; tb_b = 8'hC6; op = 3'd0; flag_c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, wb, done, flag_z, flag_n, flag_h, flag_c} !== 7'd0) begin
      n_fail++;
      $display("FAIL abort busy/wb/done/flags got=%b exp=0000000",
               {busy, wb, done, flag_z, flag_n, flag_h, flag_c});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, wb, done, flag_z, flag_n, flag_h, flag_c} !== 7'd0) begin
      n_fail++;
      $display("FAIL abort_after busy/wb/done/flags got=%b exp=0000000",
               {busy, wb, done, flag_z, flag_n, flag_h, flag_c});
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp1, exp2;
    logic [2:0]  exp_ctl;
    logic        exp_lda;
    int          last;
    exp1 = ref_alu(3'd0, 8'h3A, 8'hC6, 1'b0);
    exp2 = ref_alu(3'd1, 8'h10, 8'h20, exp1[0]);
`ifdef SM83_ALU_SEQ_B2B_EN
    last = 9;
`else
    last = 6;
`endif
    tb_a = 8'h3A; tb_b = 8'hC6; op = 3'd0; flag_c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      if (cyc == 4) begin op = 3'd1; flag_c_in = 1'b0; tb_a = 8'h10; tb_b = 8'h20; end
      if (cyc == 5) start = 1'b0;
`ifdef SM83_ALU_SEQ_B2B_EN
      exp_ctl = {cyc <= 8, cyc == 4 || cyc == 8, cyc == 5 || cyc == 9};
      exp_lda = (cyc == 1) || (cyc == 5);
`else
      exp_ctl = {cyc <= 4, cyc == 4, cyc == 5};
      exp_lda = (cyc == 1);
`endif
      n_checks++;
      if ({busy, wb, done, load_a} !== {exp_ctl, exp_lda}) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d busy/wb/done/lda got=%b exp=%b", cyc, {busy, wb, done, load_a},
                 {exp_ctl, exp_lda});
      end
`ifdef SM83_ALU_SEQ_B2B_EN
      if (cyc == 8) begin
        n_checks++;
        if ({m_res, m_lo_res} !== exp2[11:4]) begin
          n_fail++;
          $display("FAIL b2b_result got=%h exp=%h", {m_res, m_lo_res}, exp2[11:4]);
        end
      end
`endif
      if (cyc == last) begin
        n_checks++;
`ifdef SM83_ALU_SEQ_B2B_EN
        if ({flag_z, flag_n, flag_h, flag_c} !== exp2[3:0]) begin
          n_fail++;
          $display("FAIL b2b_flags got=%b exp=%b", {flag_z, flag_n, flag_h, flag_c}, exp2[3:0]);
        end
`else
        if ({flag_z, flag_n, flag_h, flag_c} !== exp1[3:0]) begin
          n_fail++;
          $display("FAIL hold_flags got=%b exp=%b", {flag_z, flag_n, flag_h, flag_c}, exp1[3:0]);
        end
`endif
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
